boot_loader_ctrl: RTL and testbench

//  Serial boot controller. Holds the processor in reset, receives a framed program image

---
 rtl/boot_loader_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_ctrl.sv
// Serial boot loader: keeps the CPU in reset, takes a framed image from the UART,
// writes it into RAM one 32-bit word at a time, then hands the RAM port to the CPU.
module boot_loader_ctrl #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 1536,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxValid,
    input  logic [7:0]  rxData,
    input  logic [31:0] cpuMemAddr,
    input  logic        cpuMemRstrb,
    input  logic [31:0] cpuMemWData,
    input  logic [3:0]  cpuMemWMask,
    output logic [31:0] ramAddr,
    output logic        ramRstrb,
    output logic [31:0] ramWData,
    output logic [3:0]  ramWMask,
    output logic        cpuReset,
    output logic        loading,
    output logic        loadDone,
    output logic        loadErr
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] SYNC = 8'hA5;

    logic [2:0]    state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   idx_q, idx_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   word_q, word_d;
    logic          wr_pend_q, wr_pend_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          load_done_q, load_done_d;
    logic          load_err_q, load_err_d;

    logic          in_frame;
    logic [TW-1:0] tmo_inc;
    logic [15:0]   len_n;

    assign in_frame = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);
    assign tmo_inc  = tmo_q + 1'b1;
    assign len_n    = {rxData, len_q[7:0]};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        byte_cnt_d  = byte_cnt_q;
        csum_d      = csum_q;
        word_d      = word_q;
        wr_pend_d   = 1'b0;
        cpu_reset_d = cpu_reset_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;

        // Index advances at the end of the one-cycle write pulse it addressed.
        if (wr_pend_q) idx_d = idx_q + 16'd1;

        if (in_frame && !rxValid) tmo_d = tmo_inc;
        else                      tmo_d = '0;

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (rxValid && rxData == SYNC) begin
                    state_d    = S_LEN_LO;
                    idx_d      = 16'd0;
                    byte_cnt_d = 2'd0;
                    csum_d     = 8'd0;
                    load_err_d = 1'b0;
                end
            end
            S_LEN_LO: begin
                if (rxValid) begin
                    len_d[7:0] = rxData;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rxValid) begin
                    len_d[15:8] = rxData;
                    if (len_n == 16'd0 || 32'(len_n) > 32'(MAX_WORDS)) begin
                        state_d    = S_ERROR;
                        load_err_d = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rxValid) begin
                    case (byte_cnt_q)
                        2'd0:    word_d[7:0]   = rxData;
                        2'd1:    word_d[15:8]  = rxData;
                        2'd2:    word_d[23:16] = rxData;
                        default: word_d[31:24] = rxData;
                    endcase
                    csum_d     = csum_q + rxData;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_pend_d = 1'b1;
                        if (idx_q == len_q - 16'd1) state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (rxValid) begin
                    if (rxData == csum_q) begin
                        state_d     = S_RUN;
                        cpu_reset_d = 1'b0;
                        load_done_d = 1'b1;
                    end else begin
                        state_d    = S_ERROR;
                        load_err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // A stalled sender abandons the frame; any partial word is simply dropped.
        if (in_frame && !rxValid && tmo_inc == TW'(TIMEOUT_CYCLES)) begin
            state_d    = S_ERROR;
            load_err_d = 1'b1;
            tmo_d      = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= 16'd0;
            idx_q       <= 16'd0;
            byte_cnt_q  <= 2'd0;
            csum_q      <= 8'd0;
            tmo_q       <= '0;
            word_q      <= 32'd0;
            wr_pend_q   <= 1'b0;
            cpu_reset_q <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            byte_cnt_q  <= byte_cnt_d;
            csum_q      <= csum_d;
            tmo_q       <= tmo_d;
            word_q      <= word_d;
            wr_pend_q   <= wr_pend_d;
            cpu_reset_q <= cpu_reset_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    always_comb begin
        if (state_q == S_RUN) begin
            ramAddr  = cpuMemAddr;
            ramRstrb = cpuMemRstrb;
            ramWData = cpuMemWData;
            ramWMask = cpuMemWMask;
        end else begin
            ramAddr  = BASE_ADDR + {14'd0, idx_q, 2'b00};
            ramRstrb = 1'b0;
            ramWData = word_q;
            ramWMask = {4{wr_pend_q}};
        end
    end

    assign cpuReset = cpu_reset_q;
    assign loading  = in_frame;
    assign loadDone = load_done_q;
    assign loadErr  = load_err_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl: frames, checksum errors, length limits,
// inter-byte timeout and reset during a write pulse.
module tb_boot_loader_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        rxValid;
    logic [7:0]  rxData;
    logic [31:0] cpuMemAddr;
    logic        cpuMemRstrb;
    logic [31:0] cpuMemWData;
    logic [3:0]  cpuMemWMask;
    logic [31:0] ramAddr;
    logic        ramRstrb;
    logic [31:0] ramWData;
    logic [3:0]  ramWMask;
    logic        cpuReset, loading, loadDone, loadErr;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } wr_t;
    wr_t wq[$];
    logic [7:0] seq[$];

    boot_loader_ctrl #(
        .BASE_ADDR     (32'h0000_0000),
        .MAX_WORDS     (1536),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rxValid    (rxValid),
        .rxData     (rxData),
        .cpuMemAddr (cpuMemAddr),
        .cpuMemRstrb(cpuMemRstrb),
        .cpuMemWData(cpuMemWData),
        .cpuMemWMask(cpuMemWMask),
        .ramAddr    (ramAddr),
        .ramRstrb   (ramRstrb),
        .ramWData   (ramWData),
        .ramWMask   (ramWMask),
        .cpuReset   (cpuReset),
        .loading    (loading),
        .loadDone   (loadDone),
        .loadErr    (loadErr)
    );

    always #5 clk = ~clk;

    // Every cycle with a nonzero mask is logged, so a stretched pulse shows up as an extra entry.
    always @(negedge clk) begin
        if (ramWMask != 4'b0000) wq.push_back('{ramAddr, ramWData, ramWMask});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        rxValid = 1'b0;
        rxData  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wq.delete();
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rxValid = 1'b1;
        rxData  = b;
        @(negedge clk);
        rxValid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_seq();
        foreach (seq[i]) send(seq[i], 2);
    endtask

    initial begin
        cpuMemAddr  = 32'h0;
        cpuMemRstrb = 1'b0;
        cpuMemWData = 32'h0;
        cpuMemWMask = 4'b0000;
        reset       = 1'b1;
        rxValid     = 1'b0;
        rxData      = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_cpuReset", {31'd0, cpuReset}, 32'd1);
        chk("rst_wmask",    {28'd0, ramWMask}, 32'd0);
        chk("rst_rstrb",    {31'd0, ramRstrb}, 32'd0);
        chk("rst_loading",  {31'd0, loading},  32'd0);
        chk("rst_done",     {31'd0, loadDone}, 32'd0);
        chk("rst_err",      {31'd0, loadErr},  32'd0);
        chk("rst_addr",     ramAddr,           32'h0);

        // 1: non-sync bytes leave the loader idle
        do_reset();
        send(8'h00, 2);
        send(8'h12, 2);
        chk("t1_loading",  {31'd0, loading},  32'd0);
        chk("t1_cpuReset", {31'd0, cpuReset}, 32'd1);
        chk("t1_nowrites", wq.size(),         32'd0);

        // 2: good two-word frame
        do_reset();
        seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
        send_seq();
        chk("t2_nwr", wq.size(), 32'd2);
        if (wq.size() == 2) begin
            chk("t2_a0", wq[0].a, 32'h0);
            chk("t2_d0", wq[0].d, 32'h0000_0013);
            chk("t2_m0", {28'd0, wq[0].m}, 32'hF);
            chk("t2_a1", wq[1].a, 32'h4);
            chk("t2_d1", wq[1].d, 32'h0000_006F);
        end
        chk("t2_done",     {31'd0, loadDone}, 32'd1);
        chk("t2_cpuReset", {31'd0, cpuReset}, 32'd0);
        chk("t2_err",      {31'd0, loadErr},  32'd0);
        cpuMemAddr  = 32'h40;
        cpuMemRstrb = 1'b1;
        cpuMemWData = 32'hCAFE_F00D;
        #1;
        chk("t2_pass_addr",  ramAddr,           32'h40);
        chk("t2_pass_rstrb", {31'd0, ramRstrb}, 32'd1);
        chk("t2_pass_wdata", ramWData,          32'hCAFE_F00D);
        send(8'hA5, 2);
        chk("t2_run_ignores_rx", {31'd0, loading}, 32'd0);
        cpuMemRstrb = 1'b0;
        cpuMemAddr  = 32'h0;

        // 3: bad checksum, then a good retry straight from ERROR
        do_reset();
        seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h6F, 8'h00, 8'h00, 8'h00, 8'h83};
        send_seq();
        chk("t3_err",      {31'd0, loadErr},  32'd1);
        chk("t3_cpuReset", {31'd0, cpuReset}, 32'd1);
        chk("t3_done",     {31'd0, loadDone}, 32'd0);
        wq.delete();
        send(8'hA5, 2);
        chk("t3_err_clr",  {31'd0, loadErr},  32'd0);
        chk("t3_loading",  {31'd0, loading},  32'd1);
        seq = '{8'h01, 8'h00, 8'h37, 8'h00, 8'h00, 8'h00, 8'h37};
        send_seq();
        chk("t3_nwr", wq.size(), 32'd1);
        if (wq.size() == 1) begin
            chk("t3_a0", wq[0].a, 32'h0);
            chk("t3_d0", wq[0].d, 32'h0000_0037);
        end
        chk("t3_done",     {31'd0, loadDone}, 32'd1);
        chk("t3_cpuRun",   {31'd0, cpuReset}, 32'd0);

        // 4: length above MAX_WORDS
        do_reset();
        seq = '{8'hA5, 8'h01, 8'h06};
        send_seq();
        chk("t4_err",     {31'd0, loadErr}, 32'd1);
        chk("t4_loading", {31'd0, loading}, 32'd0);
        chk("t4_nowr",    wq.size(),        32'd0);

        // 5: timeout 100 clocks after the last byte, partial word dropped
        do_reset();
        seq = '{8'hA5, 8'h01, 8'h00, 8'hAA};
        send_seq();
        send(8'hBB, 0);
        repeat (99) @(negedge clk);
        chk("t5_before_loading", {31'd0, loading}, 32'd1);
        chk("t5_before_err",     {31'd0, loadErr}, 32'd0);
        @(negedge clk);
        chk("t5_err",     {31'd0, loadErr}, 32'd1);
        chk("t5_loading", {31'd0, loading}, 32'd0);
        chk("t5_nowr",    wq.size(),        32'd0);

        // 6: reset lands during the second word's write pulse
        do_reset();
        seq = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        send_seq();
        send(8'h88, 0);
        chk("t6_pulse_mask", {28'd0, ramWMask}, 32'hF);
        chk("t6_pulse_addr", ramAddr,           32'h4);
        chk("t6_pulse_data", ramWData,          32'h8877_6655);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_mask",     {28'd0, ramWMask}, 32'h0);
        chk("t6_rst_addr",     ramAddr,           32'h0);
        chk("t6_rst_cpuReset", {31'd0, cpuReset}, 32'd1);
        chk("t6_rst_loading",  {31'd0, loading},  32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(8'h01, 2);
        chk("t6_idle_after", {31'd0, loading}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
